instr_fetch_unit: RTL and testbench

Instruction-fetch stage for the DLX pipeline. Consumes fetch addresses from the PC generator, performs a request/acknowledge read of instruction SRAM, and loads the IF/ID pipeline register. Honours ID-stage stall and branch redirect, and tells the PC generator when to hold its address while a fetch is outstanding.

---
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: launches SRAM reads and loads the IF/ID register, honouring stall and branch redirect.
// Latency: a word is valid in IF/ID the edge after imem_ack; a zero-wait SRAM sustains one instruction per cycle.
// Backpressure: ID stall parks an acked word in hold_buf with imem_req low; pc_hold freezes the PC generator.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        pc_hold
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fetch_ent_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] redirect_addr_q, redirect_addr_d;
    logic        redirect_pend_q, redirect_pend_d;
    fetch_ent_t  hold_buf_q, hold_buf_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;

    logic        load_req;
    logic        load_hold;

    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        redirect_addr_d = redirect_addr_q;
        redirect_pend_d = redirect_pend_q;
        hold_buf_d      = hold_buf_q;
        if_id_valid_d   = if_id_valid_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pc_d      = if_id_pc_q;
        if_id_pc4_d     = if_id_pc4_q;

        load_req  = (state_q == REQ) && imem_ack && !branch && !stall;
        load_hold = (state_q == HOLD) && !branch && !stall;

        case (state_q)
            IDLE: begin
                state_d      = REQ;
                fetch_addr_d = RESET_PC;
            end
            REQ: begin
                if (imem_ack) begin
                    if (branch) begin
                        fetch_addr_d = branch_pc;
                    end else if (stall) begin
                        hold_buf_d = '{instr: imem_rdata, addr: fetch_addr_q};
                        state_d    = HOLD;
                    end else begin
                        fetch_addr_d = pc;
                    end
                end else if (branch) begin
                    // The SRAM still owes us this read; finish it before redirecting.
                    redirect_addr_d = branch_pc;
                    redirect_pend_d = 1'b1;
                    state_d         = DRAIN;
                end
            end
            DRAIN: begin
                if (branch) begin
                    redirect_addr_d = branch_pc;
                end
                if (imem_ack && redirect_pend_q) begin
                    fetch_addr_d    = branch ? branch_pc : redirect_addr_q;
                    redirect_pend_d = 1'b0;
                    state_d         = REQ;
                end
            end
            HOLD: begin
                if (branch) begin
                    fetch_addr_d = branch_pc;
                    hold_buf_d   = '0;
                    state_d      = REQ;
                end else if (!stall) begin
                    fetch_addr_d = pc;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (branch) begin
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            if_id_valid_d = if_id_valid_q;
        end else if (load_req) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = fetch_addr_q;
            if_id_pc4_d   = fetch_addr_q + 32'd4;
        end else if (load_hold) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = hold_buf_q.instr;
            if_id_pc_d    = hold_buf_q.addr;
            if_id_pc4_d   = hold_buf_q.addr + 32'd4;
        end else begin
            if_id_valid_d = 1'b0;
        end

        imem_req_d  = (state_d == REQ) || (state_d == DRAIN);
        imem_addr_d = {fetch_addr_d[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            fetch_addr_q    <= '0;
            redirect_addr_q <= '0;
            redirect_pend_q <= 1'b0;
            hold_buf_q      <= '0;
            imem_req_q      <= 1'b0;
            imem_addr_q     <= '0;
            if_id_valid_q   <= 1'b0;
            if_id_instr_q   <= '0;
            if_id_pc_q      <= '0;
            if_id_pc4_q     <= '0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            redirect_addr_q <= redirect_addr_d;
            redirect_pend_q <= redirect_pend_d;
            hold_buf_q      <= hold_buf_d;
            imem_req_q      <= imem_req_d;
            imem_addr_q     <= imem_addr_d;
            if_id_valid_q   <= if_id_valid_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pc_q      <= if_id_pc_d;
            if_id_pc4_q     <= if_id_pc4_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    // Depends on imem_ack in the same cycle, so it cannot be registered.
    assign pc_hold     = reset | ~(load_req | load_hold);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero-wait and wait-state SRAM, stall, branch, wrap, mid-fetch reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        branch;
    logic [31:0] branch_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        pc_hold;

    int vec_cnt = 0;
    int err_cnt = 0;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .branch     (branch),
        .branch_pc  (branch_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .pc_hold    (pc_hold)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; pc = '0; branch = 1'b0; branch_pc = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (3) step();
        vec_cnt++;
        if ({imem_req, imem_addr, pc_hold} !== {1'b0, 32'h0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_req: req=%b addr=%h hold=%b exp 0/00000000/1", imem_req, imem_addr, pc_hold);
        end
        vec_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc4} !== {1'b0, 96'h0}) begin
            err_cnt++;
            $display("FAIL reset_ifid: v=%b i=%h pc=%h pc4=%h exp all zero", if_id_valid, if_id_instr, if_id_pc, if_id_pc4);
        end
        reset = 1'b0;
        step();
        vec_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0020}) begin
            err_cnt++;
            $display("FAIL first_req: req=%b addr=%h exp 1/00400020", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0040_0020 + 32'(4 * i);
            pc = a + 32'd4; imem_ack = 1'b1; imem_rdata = a;
            #1;
            vec_cnt++;
            if ({imem_addr, pc_hold} !== {a, 1'b0}) begin
                err_cnt++;
                $display("FAIL zw_addr[%0d]: addr=%h hold=%b exp %h/0", i, imem_addr, pc_hold, a);
            end
            step();
            vec_cnt++;
            if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_addr} !== {1'b1, a, a, a + 32'd4, a + 32'd4}) begin
                err_cnt++;
                $display("FAIL zw_ifid[%0d]: v=%b i=%h pc=%h pc4=%h next=%h exp instr/pc %h", i,
                         if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_addr, a);
            end
        end
        imem_ack = 1'b0;
        step();
    endtask

    task automatic test_wait_states;
        pc = 32'h0040_0100; imem_ack = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            vec_cnt++;
            if ({imem_req, imem_addr, pc_hold, if_id_valid} !== {1'b1, 32'h0040_0030, 1'b1, 1'b0}) begin
                err_cnt++;
                $display("FAIL wait[%0d]: req=%b addr=%h hold=%b v=%b exp 1/00400030/1/0", w,
                         imem_req, imem_addr, pc_hold, if_id_valid);
            end
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        vec_cnt++;
        if ({imem_req, imem_addr, pc_hold} !== {1'b1, 32'h0040_0030, 1'b0}) begin
            err_cnt++;
            $display("FAIL wait_ack: req=%b addr=%h hold=%b exp 1/00400030/0", imem_req, imem_addr, pc_hold);
        end
        step();
        vec_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_addr} !==
            {1'b1, 32'hDEAD_BEEF, 32'h0040_0030, 32'h0040_0034, 32'h0040_0100}) begin
            err_cnt++;
            $display("FAIL wait_load: v=%b i=%h pc=%h pc4=%h next=%h exp 1/deadbeef/00400030/00400034/00400100",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_addr);
        end
        imem_ack = 1'b0;
        step();
        vec_cnt++;
        if (if_id_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_bubble: v=%b exp 0", if_id_valid);
        end
    endtask

    task automatic test_stall;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111; pc = 32'h0040_0104;
        step();
        stall = 1'b1; imem_rdata = 32'h2222_2222; pc = 32'h0BAD_0000;
        #1;
        vec_cnt++;
        if (pc_hold !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_ack_hold: hold=%b exp 1", pc_hold);
        end
        step();
        imem_rdata = 32'h9999_9999;
        for (int s = 0; s < 3; s++) begin
            #1;
            vec_cnt++;
            if ({imem_req, pc_hold, if_id_valid, if_id_instr, if_id_pc} !==
                {1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h0040_0100}) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: req=%b hold=%b v=%b i=%h pc=%h exp 0/1/1/11111111/00400100", s,
                         imem_req, pc_hold, if_id_valid, if_id_instr, if_id_pc);
            end
            step();
        end
        stall = 1'b0; imem_ack = 1'b0; pc = 32'h0040_0200;
        #1;
        vec_cnt++;
        if (pc_hold !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_release_hold: hold=%b exp 0", pc_hold);
        end
        step();
        vec_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_req, imem_addr} !==
            {1'b1, 32'h2222_2222, 32'h0040_0104, 32'h0040_0108, 1'b1, 32'h0040_0200}) begin
            err_cnt++;
            $display("FAIL stall_release: v=%b i=%h pc=%h pc4=%h req=%b addr=%h exp 1/22222222/00400104/00400108/1/00400200",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_wait;
        branch = 1'b1; branch_pc = 32'h0000_1000; imem_ack = 1'b0;
        step();
        branch = 1'b0;
        vec_cnt++;
        if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0040_0200}) begin
            err_cnt++;
            $display("FAIL br_drain: v=%b req=%b addr=%h exp 0/1/00400200", if_id_valid, imem_req, imem_addr);
        end
        step();
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; pc = 32'h0040_0204;
        #1;
        vec_cnt++;
        if (pc_hold !== 1'b1) begin
            err_cnt++;
            $display("FAIL br_drain_hold: hold=%b exp 1", pc_hold);
        end
        step();
        vec_cnt++;
        if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0000_1000}) begin
            err_cnt++;
            $display("FAIL br_redirect: v=%b req=%b addr=%h exp 0/1/00001000", if_id_valid, imem_req, imem_addr);
        end
        imem_rdata = 32'h1234_0000; pc = 32'h0000_1004;
        step();
        imem_ack = 1'b0;
        vec_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 32'h1234_0000, 32'h0000_1000}) begin
            err_cnt++;
            $display("FAIL br_target_load: v=%b i=%h pc=%h exp 1/12340000/00001000", if_id_valid, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_branch_ack_stall;
        imem_ack = 1'b1; branch = 1'b1; stall = 1'b1; branch_pc = 32'h0000_2000; imem_rdata = 32'h5555_5555;
        step();
        imem_ack = 1'b0; branch = 1'b0; stall = 1'b0;
        vec_cnt++;
        if ({if_id_valid, if_id_instr, imem_req, imem_addr} !== {1'b0, 32'h1234_0000, 1'b1, 32'h0000_2000}) begin
            err_cnt++;
            $display("FAIL br_ack_stall: v=%b i=%h req=%b addr=%h exp 0/12340000/1/00002000",
                     if_id_valid, if_id_instr, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0001; pc = 32'hFFFF_FFFC;
        step();
        imem_rdata = 32'hCAFE_F00D; pc = 32'h0040_0023;
        step();
        imem_ack = 1'b0;
        vec_cnt++;
        if ({if_id_instr, if_id_pc, if_id_pc4} !== {32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0}) begin
            err_cnt++;
            $display("FAIL wrap_pc4: i=%h pc=%h pc4=%h exp cafef00d/fffffffc/00000000", if_id_instr, if_id_pc, if_id_pc4);
        end
        vec_cnt++;
        if (imem_addr !== 32'h0040_0020) begin
            err_cnt++;
            $display("FAIL misaligned_addr: addr=%h exp 00400020", imem_addr);
        end
        step();
        reset = 1'b1;
        step();
        vec_cnt++;
        if ({imem_req, if_id_valid, pc_hold, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            err_cnt++;
            $display("FAIL midfetch_reset: req=%b v=%b hold=%b addr=%h exp 0/0/1/00000000",
                     imem_req, if_id_valid, pc_hold, imem_addr);
        end
        reset = 1'b0;
        step();
        vec_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0020}) begin
            err_cnt++;
            $display("FAIL restart: req=%b addr=%h exp 1/00400020", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch_wait();
        test_branch_ack_stall();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
